spi_register_graphics_command: RTL
==================================

// Module: spi_register_graphics_command
// PURPOSE
//  SPI subperipheral that turns CPU byte streams into display commands.
//  - Decodes opcode + argument bytes from the SPI peripheral's per-byte data path.
//  - Queues validated commands in a small FIFO for the downstream graphics draw engine (valid/ready).
//  - Returns a status byte on the SPI read path.
// PARAMETERS
//  FIFO_DEPTH      4    command queue entries; power of 2, 2..8
//  DISPLAY_WIDTH   640  x coordinates must be < this, else range error
//  DISPLAY_HEIGHT  400  y coordinates must be < this, else range error
// PORTS
//  clock           in   1   system clock (72 MHz SPI domain)
//  reset           in   1   synchronous, active-high reset
//  enable          in   1   high while this subperipheral's SPI transaction is open
//  data_in         in   8   COPI byte from SPI peripheral
//  data_in_valid   in   1   1-cycle strobe per data_in byte; ignored while enable low
//  data_out        out  8   status byte
//  data_out_valid  out  1   status valid
//  cmd_valid       out  1   FIFO head valid
//  cmd_ready       in   1   draw engine accepts head this cycle
//  cmd_opcode      out  8   queued opcode
//  cmd_x           out  10  x coordinate
//  cmd_y           out  9   y coordinate
//  cmd_color       out  4   palette index
// BEHAVIOUR
//  Reset: all outputs 0; FIFO empty; flags clear; FSM IDLE. Reset mid-command drops all partial and queued data.
//  Opcodes and argument bytes:
//   - 0x01 CLR_STATUS, 0 args: clears sticky flags, not queued
//   - 0x10 CLEAR, 0 args
//   - 0x11 SET_COLOR, 1 arg: color = arg[3:0]; arg[7:4] ignored
//   - 0x12 MOVE_TO, 4 args: x_hi, x_lo, y_hi, y_lo
//   - 0x13 LINE_TO, 4 args: same argument order as MOVE_TO
//   - 0x14 SWAP, 0 args
//  Unused payload fields are queued as 0.
//  Coordinates: x = {x_hi, x_lo} as 16 bits, y likewise.
//   - Either out of range: set range_err, drop command.
//   - In range: truncate to 10 / 9 bits.
//  FSM:
//   - IDLE: on enable high -> OPCODE.
//   - OPCODE, byte received:
//     - 0-arg opcode -> act/push, go DISCARD.
//     - opcode with args -> ARGS, arg counter = argument count.
//     - unknown opcode -> set bad_op, go DISCARD.
//   - ARGS: shift bytes in; on the last byte validate and push -> DISCARD.
//   - DISCARD: extra bytes are ignored, no flag.
//   - Any state with enable low -> IDLE. Leaving ARGS this way sets trunc and discards the partial command.
//  One command per transaction: a new opcode requires enable to go low, then high again.
//  Push timing: the entry is written the cycle after the completing data_in_valid. cmd_valid rises the following cycle (2-cycle latency).
//  FIFO:
//   - Pop when cmd_valid & cmd_ready; head outputs are stable while cmd_valid & !cmd_ready.
//   - Push when full: accepted if a pop occurs the same cycle, else dropped and ovf set.
//   - Push into empty with cmd_ready high: no bypass; latency stays 2.
//  Status byte: {ovf, bad_op, trunc, range_err, count[3:0]}.
//   - Flags are sticky until CLR_STATUS or reset.
//   - data_out is registered: it reflects state 1 cycle earlier and is updated every cycle.
//   - data_out_valid = enable delayed 1 cycle.
//   - CLR_STATUS together with a new error event in the same cycle: the event wins (flag stays set).
// STRUCTURE
//  Package graphics_command_pkg:
//   - opcode enum
//   - status bit index localparams
//   - packed cmd_t {opcode, x, y, color}: 31 bits
//   - arg-count function
//  Sub-module graphics_command_fifo:
//   - sync FIFO of cmd_t, parameter DEPTH
//   - ports: push/full, pop/empty, count
//   - count wraps correctly via an extra pointer bit
//  Top level holds the FSM, argument shift register, range checks and status flags.
// TESTING
//  - MOVE_TO bytes 12 01 3F 00 C7, cmd_ready=1 -> one cmd {12, x=319, y=199, color=0}; cmd_valid 2 cycles after the last strobe.
//  - 5x SWAP (14) transactions, cmd_ready=0, depth 4 -> count=4, ovf=1, status=0x84. Then 4 pops -> opcode 14 each, count=0.
//  - LINE_TO 13 02 80 00 10 -> x=640: range_err, nothing queued. Then CLR_STATUS (01) -> status=0x00.
//  - Opcode 7F -> bad_op. SET_COLOR 11 with enable dropped before the arg -> trunc; status=0x60, FIFO empty.
//  - FIFO full with cmd_ready=1 and a push in the same cycle -> push accepted, count stays 4, ovf=0.
//  - Reset asserted mid-ARGS with 2 entries queued -> all outputs 0, count 0. Next full MOVE_TO decodes normally.

Source files
------------

// File: rtl/spi_register_graphics_command_pkg.sv
`default_nettype none
// ============================================================================
// Package     : graphics_command_pkg
// Description : Shared types for the SPI graphics command subperipheral:
//               opcode encoding, status-byte bit positions, the queued
//               command record and an argument-count helper.
// Revision    : 1.0 - initial release
// ============================================================================
package graphics_command_pkg;

  typedef enum logic [7:0] {
    OP_CLR_STATUS = 8'h01,
    OP_CLEAR      = 8'h10,
    OP_SET_COLOR  = 8'h11,
    OP_MOVE_TO    = 8'h12,
    OP_LINE_TO    = 8'h13,
    OP_SWAP       = 8'h14
  } opcode_e;

  // Bit positions of the sticky flags inside the status byte.
  localparam int STATUS_OVF    = 7;
  localparam int STATUS_BAD_OP = 6;
  localparam int STATUS_TRUNC  = 5;
  localparam int STATUS_RANGE  = 4;

  // One queued draw command (31 bits).
  typedef struct packed {
    logic [7:0] opcode;
    logic [9:0] x;
    logic [8:0] y;
    logic [3:0] color;
  } cmd_t;

  // Number of argument bytes following an opcode; 0 for zero-arg and
  // unknown opcodes.
  function automatic logic [2:0] arg_count(input logic [7:0] op);
    case (op)
      OP_SET_COLOR:         arg_count = 3'd1;
      OP_MOVE_TO, OP_LINE_TO: arg_count = 3'd4;
      default:              arg_count = 3'd0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/spi_register_graphics_command_fifo.sv
`default_nettype none
// ============================================================================
// Module      : graphics_command_fifo
// Description : Synchronous FIFO of cmd_t entries. Pointers carry one extra
//               bit so full and empty are distinguishable and the occupancy
//               count wraps correctly. Head data reads as zero when empty.
// Ports       : clock, reset       - clock, sync active-high reset
//               push, push_data    - write request and entry
//               full               - no free entry
//               pop                - remove head (ignored when empty)
//               pop_data, empty    - head entry, no entry present
//               count[3:0]         - current occupancy
// Revision    : 1.0 - initial release
// ============================================================================
module graphics_command_fifo
  import graphics_command_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  cmd_t       push_data,
  output logic       full,
  input  logic       pop,
  output cmd_t       pop_data,
  output logic       empty,
  output logic [3:0] count
);

  localparam int AW = $clog2(DEPTH);

  cmd_t          mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [AW:0]   ptr_diff;
  logic          do_push;
  logic          do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) &&
                    (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop   = pop & ~empty;
  // A push into a full queue is still accepted when the head leaves the
  // same cycle: the freed slot is the one being written.
  assign do_push  = push & (~full | do_pop);
  assign ptr_diff = wr_ptr - rd_ptr;
  assign count    = 4'(ptr_diff);
  assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule
`default_nettype wire

// File: rtl/spi_register_graphics_command.sv
`default_nettype none
// ============================================================================
// Module      : spi_register_graphics_command
// Description : SPI subperipheral decoding opcode/argument byte streams into
//               draw commands, queuing them for the draw engine and
//               reporting a status byte {ovf, bad_op, trunc, range_err,
//               count[3:0]} on the read path.
// Ports       : clock, reset               - clock, sync active-high reset
//               enable                     - SPI transaction open
//               data_in, data_in_valid     - incoming byte + strobe
//               data_out, data_out_valid   - registered status byte
//               cmd_valid, cmd_ready       - queue head handshake
//               cmd_opcode/x/y/color       - queue head fields
// Revision    : 1.0 - initial release
// ============================================================================
module spi_register_graphics_command
  import graphics_command_pkg::*;
#(
  parameter int FIFO_DEPTH     = 4,
  parameter int DISPLAY_WIDTH  = 640,
  parameter int DISPLAY_HEIGHT = 400
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic [7:0] data_in,
  input  logic       data_in_valid,
  output logic [7:0] data_out,
  output logic       data_out_valid,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [7:0] cmd_opcode,
  output logic [9:0] cmd_x,
  output logic [8:0] cmd_y,
  output logic [3:0] cmd_color
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_OPCODE  = 2'd1,
    ST_ARGS    = 2'd2,
    ST_DISCARD = 2'd3
  } state_e;

  localparam logic [15:0] X_LIMIT = 16'(DISPLAY_WIDTH);
  localparam logic [15:0] Y_LIMIT = 16'(DISPLAY_HEIGHT);

  state_e      state, state_next;
  logic [2:0]  arg_cnt, arg_cnt_next;
  logic [23:0] arg_sr, arg_sr_next;     // previous three argument bytes
  logic [7:0]  op_reg, op_next;
  logic        push_pend, push_next;
  cmd_t        push_cmd, push_cmd_next;
  logic [3:0]  flags, flags_next;       // {ovf, bad_op, trunc, range_err}

  logic        strobe;
  logic        clr;
  logic        evt_bad, evt_trunc, evt_range, evt_ovf;
  logic [15:0] x16, y16;

  logic        fifo_full, fifo_empty, fifo_pop;
  logic [3:0]  fifo_count;
  cmd_t        head;

  assign strobe = enable & data_in_valid;
  // Coordinates as they stand when the final argument byte arrives.
  assign x16    = arg_sr[23:8];
  assign y16    = {arg_sr[7:0], data_in};

  always_comb begin
    state_next    = state;
    arg_cnt_next  = arg_cnt;
    arg_sr_next   = arg_sr;
    op_next       = op_reg;
    push_next     = 1'b0;
    push_cmd_next = push_cmd;
    clr           = 1'b0;
    evt_bad       = 1'b0;
    evt_trunc     = 1'b0;
    evt_range     = 1'b0;

    if (!enable) begin
      state_next = ST_IDLE;
      if (state == ST_ARGS) evt_trunc = 1'b1;
    end else begin
      case (state)
        ST_IDLE: state_next = ST_OPCODE;

        ST_OPCODE: begin
          if (strobe) begin
            op_next    = data_in;
            state_next = ST_DISCARD;
            if (data_in == OP_CLR_STATUS) begin
              clr = 1'b1;
            end else if (arg_count(data_in) != 3'd0) begin
              state_next   = ST_ARGS;
              arg_cnt_next = arg_count(data_in);
            end else if (data_in == OP_CLEAR || data_in == OP_SWAP) begin
              push_next            = 1'b1;
              push_cmd_next        = '0;
              push_cmd_next.opcode = data_in;
            end else begin
              evt_bad = 1'b1;
            end
          end
        end

        ST_ARGS: begin
          if (strobe) begin
            arg_sr_next  = {arg_sr[15:0], data_in};
            arg_cnt_next = arg_cnt - 3'd1;
            if (arg_cnt == 3'd1) begin
              state_next           = ST_DISCARD;
              push_cmd_next        = '0;
              push_cmd_next.opcode = op_reg;
              if (op_reg == OP_SET_COLOR) begin
                push_cmd_next.color = data_in[3:0];
                push_next           = 1'b1;
              end else if (x16 < X_LIMIT && y16 < Y_LIMIT) begin
                push_cmd_next.x = x16[9:0];
                push_cmd_next.y = y16[8:0];
                push_next       = 1'b1;
              end else begin
                evt_range = 1'b1;
              end
            end
          end
        end

        ST_DISCARD: ;

        default: state_next = ST_IDLE;
      endcase
    end
  end

  assign fifo_pop = ~fifo_empty & cmd_ready;
  assign evt_ovf  = push_pend & fifo_full & ~fifo_pop;
  // A new event in the same cycle as a clear keeps its flag set.
  assign flags_next = (flags & {4{~clr}}) | {evt_ovf, evt_bad, evt_trunc, evt_range};

  always_ff @(posedge clock) begin
    if (reset) begin
      state          <= ST_IDLE;
      arg_cnt        <= '0;
      arg_sr         <= '0;
      op_reg         <= '0;
      push_pend      <= 1'b0;
      push_cmd       <= '0;
      flags          <= '0;
      data_out       <= '0;
      data_out_valid <= 1'b0;
    end else begin
      state          <= state_next;
      arg_cnt        <= arg_cnt_next;
      arg_sr         <= arg_sr_next;
      op_reg         <= op_next;
      push_pend      <= push_next;
      push_cmd       <= push_cmd_next;
      flags          <= flags_next;
      data_out       <= {flags, fifo_count};
      data_out_valid <= enable;
    end
  end

  graphics_command_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (push_pend),
    .push_data (push_cmd),
    .full      (fifo_full),
    .pop       (fifo_pop),
    .pop_data  (head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  assign cmd_valid  = ~fifo_empty;
  assign cmd_opcode = head.opcode;
  assign cmd_x      = head.x;
  assign cmd_y      = head.y;
  assign cmd_color  = head.color;

endmodule
`default_nettype wire
